// File: rtl/mdu_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  // Operation encodings driven on the op input.
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  // Control states: wait for start, iterate, then sign-fix and write back.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers.
// Multiply is MSB-first shift-add over the multiplier magnitude; divide is
// restoring division with the dividend magnitude fed in MSB-first. Both use
// unsigned magnitudes and fix the signs in the final FIX cycle.
//
// Handshake: start is sampled only in IDLE. busy stays high from the edge
// after start until the FIX edge; done pulses for one cycle after FIX, which
// is also the first cycle in which a new start is accepted.
module mdu #(
  parameter int WIDTH = mdu_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             whi,
  input  logic             wlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mdu_pkg::*;

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  mdu_state_e           r_state;
  mdu_state_e           w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]     r_ma;
  logic [WIDTH-1:0]     r_mb;
  logic                 r_sa;
  logic                 r_sb;
  logic                 r_is_div;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;

  logic                 w_is_signed;
  logic                 w_sa;
  logic                 w_sb;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_trial;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic                 w_div_zero;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // MULT and DIV (op[0]=0) treat operands as signed.
  assign w_is_signed = ~op[0];
  assign w_sa        = w_is_signed & a[WIDTH-1];
  assign w_sb        = w_is_signed & b[WIDTH-1];

  // FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state: 32 RUN cycles counted down to zero, then one FIX cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)         w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == '0)   w_state_nxt = ST_FIX;
      ST_FIX:                     w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // One multiply or divide step per RUN cycle; r_cnt selects the operand bit.
  always_comb begin
    w_acc_nxt = r_acc;
    w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_ma[r_cnt]};
    w_trial   = w_rem_sh - {1'b0, r_mb};
    if (r_is_div) begin
      if (!w_trial[WIDTH]) w_acc_nxt = {w_trial[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};
      else                 w_acc_nxt = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else begin
      w_acc_nxt = {r_acc[2*WIDTH-2:0], 1'b0} +
                  (r_mb[r_cnt] ? {{WIDTH{1'b0}}, r_ma} : {2*WIDTH{1'b0}});
    end
  end

  // Sign correction applied in FIX. A zero divisor yields quotient all-ones
  // and remainder equal to the original dividend.
  always_comb begin
    w_prod     = cneg2(r_acc, r_sa ^ r_sb);
    w_quo      = cneg(r_acc[WIDTH-1:0], r_sa ^ r_sb);
    w_rem      = cneg(r_acc[2*WIDTH-1:WIDTH], r_sa);
    w_div_zero = (r_mb == '0);
  end

  // Operand latch, iteration state, HI/LO writes and the done pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_is_div <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FIX);
      case (r_state)
        ST_IDLE: begin
          if (whi) r_hi <= wdata;
          if (wlo) r_lo <= wdata;
          if (start) begin
            r_ma     <= w_is_signed ? abs_val(a) : a;
            r_mb     <= w_is_signed ? abs_val(b) : b;
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_is_div <= op[1];
            r_acc    <= '0;
            r_cnt    <= CNT_LAST;
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_nxt;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        ST_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_div_zero ? {WIDTH{1'b1}} : w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases, random ops against an
// arithmetic reference model, write-port and reset-abort behaviour.
module tb_mdu;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        whi;
  logic        wlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_hi;

  mdu dut (
    .clock (clock),
    .resetn(resetn),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .whi   (whi),
    .wlo   (wlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Clock generation.
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operand values.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] res;
    logic [63:0] qv;
    logic [63:0] rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00:   res = 64'(sx * sy);
      2'b01:   res = {32'b0, x} * {32'b0, y};
      default: begin
        if (y == 32'd0) begin
          res = {x, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
          q  = sx / sy;
          r  = sx % sy;
          qv = 64'(q);
          rv = 64'(r);
          res = {rv[31:0], qv[31:0]};
        end else begin
          res = {x % y, x / y};
        end
      end
    endcase
    return res;
  endfunction

  // Issue one op from IDLE (time is #1 after a posedge) and check latency,
  // busy, result and single-cycle done. inj>0 pulses start+whi before edge E<inj>.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int inj, input string tag);
    int          lat;
    logic [63:0] e;
    lat   = 0;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back(model(o, x, y));
    @(posedge clock); #1;
    start = 1'b0;
    whi   = 1'b0;
    wlo   = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom_range(0, 3));
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    for (int k = 1; k <= 40; k++) begin
      if (k == inj) begin
        start = 1'b1;
        op    = 2'b10;
        whi   = 1'b1;
        wdata = 32'h0000_DEAD;
      end
      @(posedge clock); #1;
      start = 1'b0;
      whi   = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    e = exp_q.pop_front();
    exp_hi = e[63:32];
    check({tag, " latency"}, 64'(lat), 64'd33);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " result"}, {hi, lo}, e);
    @(posedge clock); #1;
    check({tag, " done_single"}, 64'(done), 64'd0);
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    a      = '0;
    b      = '0;
    whi    = 1'b0;
    wlo    = 1'b0;
    wdata  = '0;
    exp_hi = '0;

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", {30'b0, busy, done, hi, lo}, 64'd0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // Directed arithmetic cases.
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7,          0, "mult_neg");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  0, "multu_max");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,          0, "div_neg");
    run_op(2'b11, 32'd100,       32'd7,          0, "divu_100_7");
    run_op(2'b11, 32'h0000_1234, 32'd0,          0, "divu_zero");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0,          0, "div_neg_zero");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  0, "div_ovf");
    run_op(2'b10, 32'd7,         32'hFFFF_FFFE,  0, "div_pos_neg");

    // start and MTHI during a running MULTU are ignored.
    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0,  5, "multu_busy_inj");

    // MTLO in IDLE lands on the next edge and leaves HI alone.
    wlo   = 1'b1;
    wdata = 32'h0000_0055;
    @(posedge clock); #1;
    wlo   = 1'b0;
    check("mtlo_idle", {hi, lo}, {exp_hi, 32'h0000_0055});

    // MTHI in IDLE.
    whi   = 1'b1;
    wdata = 32'hCAFE_0001;
    @(posedge clock); #1;
    whi   = 1'b0;
    check("mthi_idle", {hi, lo}, {32'hCAFE_0001, 32'h0000_0055});

    // MTHI together with start: overwritten by the op result.
    whi   = 1'b1;
    wdata = 32'hBEEF_BEEF;
    run_op(2'b00, 32'hFFFF_0000, 32'h0001_0000, 0, "mthi_with_start");

    // Randomized ops against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 5) == 0) ra = 32'($urandom_range(0, 255));
      run_op(ro, ra, rb, 0, "random");
    end

    // Reset in the middle of a DIV aborts with everything cleared.
    op    = 2'b10;
    a     = 32'hFFFF_FF00;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    check("reset_mid_op", {30'b0, busy, done, hi, lo}, 64'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    check("after_reset_idle", {30'b0, busy, done, hi, lo}, 64'd0);
    run_op(2'b01, 32'd3, 32'd5, 0, "multu_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL timeout: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
